node_ctrl: RTL
==============

// Module: node_ctrl
// PURPOSE
//  Instruction sequencer for one TIS node. Decodes the i_t word from irom at the current pc.
//  Drives acc (wen/sav/swp), alu (aluop, operand_b), pc (jump_pc/jump_pc_en/stall) and nodeio (tx/rx).
//  Owns every multi-cycle case: blocking port reads/writes, port->port MOV, halt.
//  Sits inside node between irom and the acc/alu/pc/nodeio datapath.
// PARAMETERS
//  IROM_DEPTH  15  program slots; JRO targets clamp to [0, IROM_DEPTH-1]
//  WORD_W      11  signed data width (word_t); values kept in [-999, 999] by alu
// PORTS
//  CLK           in   1      clock, rising edge
//  nRST          in   1      synchronous reset, active low
//  halt          in   1      freeze node; no new instruction issues
//  instr         in   15     i_t {opcode[14:11], imm[10:0]}; src=imm[2:0], dst=imm[6:4]
//  pc            in   4      current pc_t
//  acc           in   11     current acc value
//  in_data       in   11     word from nodeio; valid when rx_complete
//  rx_complete   in   1      nodeio read finished this cycle
//  tx_complete   in   1      nodeio write accepted this cycle
//  aluop         out  2      PASS_B / ADD / SUB / NEG (acc is operand_a)
//  operand_b     out  11     resolved source value or immediate
//  acc_wen       out  1      load alu_result into acc
//  acc_sav       out  1      SAV strobe
//  acc_swp       out  1      SWP strobe
//  jump_pc       out  4      branch target
//  jump_pc_en    out  1      take jump_pc at next edge
//  stall         out  1      hold pc
//  rx, tx        out  1      nodeio requests, held until matching *_complete
//  direction     out  3      src_t port selector for rx/tx
//  out_data      out  11     write data for tx
// BEHAVIOUR
//  - Encodings (src_t): 0 ACC, 1 NIL, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT, 6 ANY, 7 LAST.
//  - Opcodes: 0 NOP, 1 MOV, 2 MOVI, 3 SWP, 4 SAV, 5 ADD, 6 ADDI, 7 SUB, 8 SUBI, 9 NEG.
//  - Opcodes (cont.): A JMP, B JEZ, C JNZ, D JGZ, E JLZ, F JRO. Immediate = imm sign-extended.
//  - Reset: state=EXEC; all outputs 0; stall=0; port hold reg=0.
//  - FSM states: EXEC, RD_WAIT, WR_WAIT, HALTED.
//  - EXEC, no port operand: single cycle. Controls are combinational from instr; stall=0.
//  - EXEC, port source: rx=1, stall=1 -> RD_WAIT.
//  - RD_WAIT on rx_complete: execute with operand_b=in_data, stall=0 -> EXEC.
//  - RD_WAIT exception: if dst is also a port, latch in_data into hold reg and stay stalled -> WR_WAIT.
//  - EXEC, MOV to port: tx=1, out_data=src value (or hold reg), stall=1 -> WR_WAIT.
//  - WR_WAIT: stall=0 in the tx_complete cycle -> EXEC.
//  - dst ACC: acc_wen=1. dst NIL: discard.
//  - src NIL reads 0 with no rx.
//  - Jumps: condition evaluated on acc in the issue cycle; jump_pc_en=1 only if taken.
//  - JRO: target = pc + src value, saturated to [0, IROM_DEPTH-1]. Negative results go to 0.
//  - halt=1 from any state -> HALTED. Drop rx/tx, outputs 0, stall=1.
//  - On halt release: re-issue the same pc from EXEC; any partial transfer restarts.
//  - rx_complete/tx_complete outside the matching wait state: ignored.
//  - A complete arriving in the same cycle halt rises: halt wins, data discarded.
//  - nRST low mid-transfer: abort at the next edge. No tx/rx held after reset.
// CONFIGURATION
//  - NODE_CTRL_ANY_LAST_EN defined:
//    - ANY asserts rx/tx with direction=ANY; nodeio resolves which port.
//    - The direction nodeio reports on completion is latched as LAST (reset: NIL).
//    - LAST uses the latched direction; LAST while still NIL behaves as NIL.
//  - NODE_CTRL_ANY_LAST_EN undefined: ANY and LAST behave as NIL (read 0, write discarded).
// STRUCTURE
//  - types_pkg: opcode_t enum, src_t enum, aluop_t, word_t, pc_t, i_t struct, WORD_MAX/MIN=+/-999.
//  - Sub-module node_decode (combinational): instr -> {is_port_src, is_port_dst, aluop, imm_sext, jump_cond}.
//  - The FSM and hold/LAST registers stay in node_ctrl.
// TESTING
//  1. Reset mid-RD_WAIT: rx, stall, acc_wen all 0 the next cycle; state EXEC.
//  2. ADDI 5 with acc=10: aluop=ADD, operand_b=5, acc_wen=1, stall=0, single cycle.
//  3. MOV UP,ACC; rx_complete after 3 cycles, in_data=-7: stall=1 for 3 cycles, then acc_wen=1, operand_b=-7.
//  4. MOV LEFT,RIGHT; in_data=42 after 2 cycles, tx_complete after 4 more: out_data=42, stall released only in the tx_complete cycle.
//  5. JRO with src=-20, pc=3: jump_pc=0. With src=+30: jump_pc=14. jump_pc_en=1 both.
//  6. JEZ with acc=0: jump_pc_en=1. With acc=1: jump_pc_en=0.
//  7. ANY/LAST (macro on): ANY read completing from DOWN, then MOV LAST,ACC issues rx with direction=DOWN.
//  8. ANY/LAST (macro off): MOV ANY,ACC gives acc_wen=1, operand_b=0, no rx.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the TIS node control path: opcodes, port selectors, ALU ops, data words.
// Also holds the JRO target helper.
package types_pkg;

  localparam int unsigned IROM_DEPTH = 15;
  localparam int unsigned WORD_W     = 11;
  localparam int unsigned PC_W       = 4;
  localparam int          PC_MAX     = IROM_DEPTH - 1;
  localparam int          WORD_MAX   = 999;
  localparam int          WORD_MIN   = -999;

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic [PC_W-1:0]          pc_t;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpMov  = 4'h1,
    OpMovi = 4'h2,
    OpSwp  = 4'h3,
    OpSav  = 4'h4,
    OpAdd  = 4'h5,
    OpAddi = 4'h6,
    OpSub  = 4'h7,
    OpSubi = 4'h8,
    OpNeg  = 4'h9,
    OpJmp  = 4'hA,
    OpJez  = 4'hB,
    OpJnz  = 4'hC,
    OpJgz  = 4'hD,
    OpJlz  = 4'hE,
    OpJro  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    SrcAcc   = 3'd0,
    SrcNil   = 3'd1,
    SrcUp    = 3'd2,
    SrcDown  = 3'd3,
    SrcLeft  = 3'd4,
    SrcRight = 3'd5,
    SrcAny   = 3'd6,
    SrcLast  = 3'd7
  } src_t;

  typedef enum logic [1:0] {
    AluPassB = 2'd0,
    AluAdd   = 2'd1,
    AluSub   = 2'd2,
    AluNeg   = 2'd3
  } aluop_t;

  typedef enum logic [2:0] {
    JcNone,
    JcAlways,
    JcEz,
    JcNz,
    JcGz,
    JcLz,
    JcRel
  } jump_cond_t;

  typedef struct packed {
    opcode_t            opcode;
    logic [WORD_W-1:0]  imm;
  } i_t;

  // ANY counts as a port: it needs a nodeio handshake even though nodeio picks the side.
  function automatic logic is_port(src_t s);
    return (s >= SrcUp) && (s <= SrcAny);
  endfunction

  function automatic pc_t jro_target(pc_t pc, word_t off);
    int sum;
    sum = int'(pc) + int'(off);
    if (sum < 0) return '0;
    if (sum > PC_MAX) return pc_t'(PC_MAX);
    return pc_t'(sum);
  endfunction

endpackage

// File: rtl/node_decode.sv
// Combinational instruction decode for node_ctrl. With NODE_CTRL_ANY_LAST_EN defined, ANY stays
// a port selector; otherwise ANY (and LAST, via a NIL last_dir) collapse to NIL.
module node_decode
  import types_pkg::*;
(
  input  i_t         instr,
  input  src_t       last_dir,
  output opcode_t    opcode,
  output src_t       src_dir,
  output src_t       dst_dir,
  output logic       is_port_src,
  output logic       is_port_dst,
  output aluop_t     aluop,
  output word_t      imm_sext,
  output logic       acc_write,
  output logic       b_from_imm,
  output jump_cond_t jump_cond
);

`ifdef NODE_CTRL_ANY_LAST_EN
  localparam bit AnyEn = 1'b1;
`else
  localparam bit AnyEn = 1'b0;
`endif

  src_t raw_src;
  src_t raw_dst;
  logic uses_src;

  assign opcode   = instr.opcode;
  assign raw_src  = src_t'(instr.imm[2:0]);
  assign raw_dst  = src_t'(instr.imm[6:4]);
  assign imm_sext = $signed(instr.imm);

  always_comb begin
    src_dir = (raw_src == SrcLast) ? last_dir : raw_src;
    dst_dir = (raw_dst == SrcLast) ? last_dir : raw_dst;
    if (!AnyEn && (src_dir == SrcAny)) src_dir = SrcNil;
    if (!AnyEn && (dst_dir == SrcAny)) dst_dir = SrcNil;
  end

  assign uses_src    = opcode inside {OpMov, OpAdd, OpSub, OpJro};
  assign is_port_src = uses_src && is_port(src_dir);
  assign is_port_dst = (opcode == OpMov) && is_port(dst_dir);

  always_comb begin
    aluop      = AluPassB;
    acc_write  = 1'b0;
    b_from_imm = 1'b0;
    jump_cond  = JcNone;
    case (opcode)
      OpMov:  acc_write = (dst_dir == SrcAcc);
      OpMovi: begin
        acc_write  = 1'b1;
        b_from_imm = 1'b1;
      end
      OpAdd:  begin
        aluop     = AluAdd;
        acc_write = 1'b1;
      end
      OpAddi: begin
        aluop      = AluAdd;
        acc_write  = 1'b1;
        b_from_imm = 1'b1;
      end
      OpSub:  begin
        aluop     = AluSub;
        acc_write = 1'b1;
      end
      OpSubi: begin
        aluop      = AluSub;
        acc_write  = 1'b1;
        b_from_imm = 1'b1;
      end
      OpNeg:  begin
        aluop     = AluNeg;
        acc_write = 1'b1;
      end
      OpJmp:  jump_cond = JcAlways;
      OpJez:  jump_cond = JcEz;
      OpJnz:  jump_cond = JcNz;
      OpJgz:  jump_cond = JcGz;
      OpJlz:  jump_cond = JcLz;
      OpJro:  jump_cond = JcRel;
      default: ;
    endcase
  end

endmodule

// File: rtl/node_ctrl.sv
// Instruction sequencer for one TIS node: issues datapath controls and runs blocking port transfers.
// NODE_CTRL_ANY_LAST_EN enables ANY port resolution by nodeio and the LAST direction register.
module node_ctrl
  import types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  i_t          instr,
  input  pc_t         pc,
  input  word_t       acc,
  input  word_t       in_data,
  input  logic        rx_complete,
  input  logic        tx_complete,
  input  logic [2:0]  complete_dir,
  output aluop_t      aluop,
  output word_t       operand_b,
  output logic        acc_wen,
  output logic        acc_sav,
  output logic        acc_swp,
  output pc_t         jump_pc,
  output logic        jump_pc_en,
  output logic        stall,
  output logic        rx,
  output logic        tx,
  output src_t        direction,
  output word_t       out_data
);

  typedef enum logic [1:0] {StExec, StRdWait, StWrWait, StHalted} state_t;

  state_t     state_q, state_d;
  word_t      hold_q, hold_d;
  src_t       last_dir;

  opcode_t    opcode;
  src_t       src_dir;
  src_t       dst_dir;
  logic       is_port_src;
  logic       is_port_dst;
  aluop_t     dec_aluop;
  word_t      imm_sext;
  logic       acc_write;
  logic       b_from_imm;
  jump_cond_t jump_cond;

  word_t      local_val;
  word_t      b_val;
  logic       do_exec;
  logic       taken;

  node_decode u_decode (
    .instr       (instr),
    .last_dir    (last_dir),
    .opcode      (opcode),
    .src_dir     (src_dir),
    .dst_dir     (dst_dir),
    .is_port_src (is_port_src),
    .is_port_dst (is_port_dst),
    .aluop       (dec_aluop),
    .imm_sext    (imm_sext),
    .acc_write   (acc_write),
    .b_from_imm  (b_from_imm),
    .jump_cond   (jump_cond)
  );

  // Non-port sources: ACC or zero (NIL, and ANY/LAST when they resolve to nothing).
  assign local_val = (src_dir == SrcAcc) ? acc : '0;
  assign b_val     = b_from_imm ? imm_sext : ((state_q == StRdWait) ? in_data : local_val);

  always_comb begin
    unique case (jump_cond)
      JcAlways: taken = 1'b1;
      JcEz:     taken = (acc == '0);
      JcNz:     taken = (acc != '0);
      JcGz:     taken = !acc[WORD_W-1] && (acc != '0);
      JcLz:     taken = acc[WORD_W-1];
      JcRel:    taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    aluop      = AluPassB;
    operand_b  = '0;
    acc_wen    = 1'b0;
    acc_sav    = 1'b0;
    acc_swp    = 1'b0;
    jump_pc    = '0;
    jump_pc_en = 1'b0;
    stall      = 1'b0;
    rx         = 1'b0;
    tx         = 1'b0;
    direction  = SrcAcc;
    out_data   = '0;
    state_d    = state_q;
    hold_d     = hold_q;
    do_exec    = 1'b0;

    if (!nRST) begin
      state_d = StExec;
    end else if (halt) begin
      // Halt overrides any completion arriving this cycle.
      stall   = 1'b1;
      state_d = StHalted;
    end else begin
      unique case (state_q)
        StExec: begin
          if (is_port_src) begin
            rx        = 1'b1;
            direction = src_dir;
            stall     = 1'b1;
            state_d   = StRdWait;
          end else begin
            do_exec = 1'b1;
          end
        end
        StRdWait: begin
          rx        = 1'b1;
          direction = src_dir;
          stall     = 1'b1;
          if (rx_complete) begin
            if (is_port_dst) begin
              hold_d  = in_data;
              state_d = StWrWait;
            end else begin
              do_exec = 1'b1;
              stall   = 1'b0;
              state_d = StExec;
            end
          end
        end
        StWrWait: begin
          tx        = 1'b1;
          direction = dst_dir;
          out_data  = hold_q;
          stall     = 1'b1;
          if (tx_complete) begin
            stall   = 1'b0;
            state_d = StExec;
          end
        end
        StHalted: begin
          // One quiet cycle after release; the held pc is re-issued from StExec.
          stall   = 1'b1;
          state_d = StExec;
        end
        default: state_d = StExec;
      endcase

      if (do_exec) begin
        if (acc_write) begin
          aluop     = dec_aluop;
          operand_b = (dec_aluop == AluNeg) ? '0 : b_val;
          acc_wen   = 1'b1;
        end
        acc_sav = (opcode == OpSav);
        acc_swp = (opcode == OpSwp);
        if (is_port_dst) begin
          tx        = 1'b1;
          direction = dst_dir;
          out_data  = b_val;
          hold_d    = b_val;
          stall     = 1'b1;
          state_d   = StWrWait;
        end
        if (taken) begin
          jump_pc_en = 1'b1;
          jump_pc    = (jump_cond == JcRel) ? jro_target(pc, b_val) : imm_sext[PC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StExec;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef NODE_CTRL_ANY_LAST_EN
  src_t last_q, last_d;
  logic cdir_ok;

  assign cdir_ok  = (complete_dir >= 3'd2) && (complete_dir <= 3'd5);
  assign last_dir = last_q;

  // Remember which side an ANY transfer actually used.
  always_comb begin
    last_d = last_q;
    if (nRST && !halt && (direction == SrcAny) && cdir_ok &&
        (((state_q == StRdWait) && rx_complete) || ((state_q == StWrWait) && tx_complete))) begin
      last_d = src_t'(complete_dir);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) last_q <= SrcNil;
    else       last_q <= last_d;
  end
`else
  logic unused_complete_dir;

  assign last_dir            = SrcNil;
  assign unused_complete_dir = ^complete_dir;
`endif

endmodule
